// File: rtl/cfg_shadow_regfile.sv
// rtl/cfg_shadow_regfile.sv - shadowed configuration register file with atomic commit, live registers and sticky lock
module cfg_shadow_regfile #(
    parameter int                             ADDR_W    = 5,
    parameter int                             DATA_W    = 10,
    parameter int                             NUM_REGS  = 24,
    parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL = '0,
    parameter logic [NUM_REGS-1:0]            LIVE_MASK = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [NUM_REGS*DATA_W-1:0]  cfg_out,
    output logic                        cfg_update,
    output logic                        pending,
    output logic                        locked
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] ADDR_COMMIT = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LOCK   = ADDR_W'(NUM_REGS + 1);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(NUM_REGS + 2);

    if (NUM_REGS + 3 > (1 << ADDR_W)) begin : g_addr_check
        $error("cfg_shadow_regfile: NUM_REGS+3 does not fit in ADDR_W address bits");
    end
    if (DATA_W < 2) begin : g_width_check
        $error("cfg_shadow_regfile: DATA_W must be at least 2 to hold the status word");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   active_q [NUM_REGS];
    logic                pending_q;
    logic                locked_q;

    logic                is_reg;
    logic                is_commit;
    logic                is_lock;
    logic                is_status;
    logic                is_bad;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   rd_data;
    logic                acc_err;
    logic                accept;

    assign is_reg    = (req_addr < ADDR_COMMIT);
    assign is_commit = (req_addr == ADDR_COMMIT);
    assign is_lock   = (req_addr == ADDR_LOCK);
    assign is_status = (req_addr == ADDR_STATUS);
    assign is_bad    = !(is_reg || is_commit || is_lock || is_status);
    assign idx       = IDX_W'(req_addr);

    // Reset gates the ready so nothing can be accepted on the reset edge itself.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign pending   = pending_q;
    assign locked    = locked_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
        assign cfg_out[g*DATA_W +: DATA_W] = active_q[g];
    end

    always_comb begin
        rd_data = '0;
        acc_err = 1'b0;
        if (req_write) begin
            if (is_bad || is_status) begin
                acc_err = 1'b1;
            end else if (locked_q) begin
                acc_err = 1'b1;
            end
        end else begin
            if (is_reg) begin
                rd_data = shadow_q[idx];
            end else if (is_lock) begin
                rd_data = {{(DATA_W-1){1'b0}}, locked_q};
            end else if (is_status) begin
                rd_data = {{(DATA_W-2){1'b0}}, locked_q, pending_q};
            end else if (is_bad) begin
                acc_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cfg_update <= 1'b0;
            pending_q  <= 1'b0;
            locked_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
                active_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            cfg_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= req_write ? '0 : rd_data;
                        rsp_err   <= acc_err;
                        if (req_write && !acc_err) begin
                            if (is_reg) begin
                                shadow_q[idx] <= req_wdata;
                                if (LIVE_MASK[idx]) begin
                                    active_q[idx] <= req_wdata;
                                    cfg_update    <= 1'b1;
                                end else begin
                                    pending_q <= 1'b1;
                                end
                            end else if (is_commit) begin
                                // All non-live registers move together so multi-register settings land atomically.
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (!LIVE_MASK[i]) begin
                                        active_q[i] <= shadow_q[i];
                                    end
                                end
                                pending_q  <= 1'b0;
                                cfg_update <= 1'b1;
                            end else if (is_lock && req_wdata[0]) begin
                                locked_q <= 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cfg_shadow_regfile.md
# cfg_shadow_regfile

Parametrised configuration register file that generalises the fixed PLL/TRNG/noise address decoder into N registers of configurable width. Each register has a shadow copy and an active copy, with atomic commit, per-register live (immediate) mode, a sticky lock and a read-back path. A valid/ready request/response handshake replaces the bare `valid` strobe. It sits between the scan/config access port and the analog-macro control inputs (PLL ratio and mode, TRNG selects, noise selects), so multi-register settings such as the three PLL ratios change in the same cycle.

## Interface
- `ADDR_W`, 5, request address width.
- `DATA_W`, 10, register and data width.
- `NUM_REGS`, 24, number of configuration registers; NUM_REGS+3 ≤ 2^ADDR_W (elaboration error otherwise).
- `RESET_VAL`, '0, packed NUM_REGS×DATA_W reset image; register i is at [i*DATA_W +: DATA_W].
- `LIVE_MASK`, '0, NUM_REGS bits; bit i=1 makes register i bypass the shadow and update its active copy on write.
- Special addresses: COMMIT=NUM_REGS, LOCK=NUM_REGS+1, STATUS=NUM_REGS+2.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when req_valid&req_ready.
- `req_write`  in  1  1=write, 0=read.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when rsp_valid&rsp_ready.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes.
- `rsp_err`  out  1  request rejected (bad address or locked).
- `cfg_out`  out  NUM_REGS×DATA_W  active register image driving the macros.
- `cfg_update`  out  1  one-cycle pulse when any active register changes.
- `pending`  out  1  shadow holds uncommitted writes.
- `locked`  out  1  sticky lock state.

## Operation
- FSM has two states. IDLE: req_ready=1. RESP: rsp_valid=1, req_ready=0.
- IDLE→RESP on accept. RESP→IDLE on rsp_ready. One outstanding request max.
- Write to addr i<NUM_REGS, unlocked:
  - shadow[i]←wdata.
  - If LIVE_MASK[i]: active[i]←wdata and cfg_update pulses.
  - Else pending←1.
- Write to COMMIT, unlocked: active←shadow for all non-live registers, pending←0, cfg_update pulses. wdata is ignored. Commit with pending=0 still pulses cfg_update.
- Write to LOCK with wdata[0]=1: locked←1. wdata[0]=0 has no effect. Lock is cleared only by rst.
- When locked, writes to registers, COMMIT or LOCK have no effect and return rsp_err=1. Shadow, active and pending are unchanged.
- Read of i<NUM_REGS returns shadow[i]. For a live register this equals active[i].
- Read of COMMIT returns 0.
- Read of LOCK returns {0…,locked}.
- Read of STATUS returns {0…,locked,pending} (bit1=locked, bit0=pending).
- Addresses ≥ NUM_REGS+3: rsp_err=1, rsp_rdata=0, no state change. STATUS write: rsp_err=1.
- Read data is captured at accept. Later state changes do not alter a held response.

## Timing
- Reset values:
  - shadow = active = RESET_VAL, so cfg_out=RESET_VAL.
  - pending=0, locked=0, state=IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, cfg_update=0.
  - req_ready=0 while rst=1; req_ready=1 in the first cycle after rst falls.
- Accept at edge T: register/active/pending/locked updates are visible after T. rsp_valid=1 and cfg_update (if any) are both high in cycle T+1.
- Throughput: with rsp_ready tied to 1, one request every 2 cycles.
- rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready. req_ready stays 0 throughout.
- cfg_out changes only at a live write or a commit edge. It never glitches between commits for non-live registers.
- rst asserted mid-transaction: the response is dropped, all state returns to reset values at the next edge, and no cfg_update pulse is produced.
- Simultaneous events cannot occur: single request port, one in flight.

## Test plan
(NUM_REGS=24, DATA_W=10, RESET_VAL[0]=0xBC, LIVE_MASK=bit3 only)
1. Reset, then read addr 0 → rsp_rdata=0xBC, rsp_err=0. cfg_out[0]=0xBC, pending=0.
2. Write 0x123 to addr 0, then 0x045 to addr 1:
   - cfg_out[0..1] unchanged; STATUS read returns 0x001.
   - Write COMMIT → in one cycle cfg_out[0]=0x123 and cfg_out[1]=0x045, cfg_update pulses exactly once, pending=0.
3. Write 0x001 to live addr 3 → cfg_out[3]=0x001 the cycle after accept, cfg_update pulses, pending stays 0.
4. Write LOCK with 0x001:
   - Then write 0x3FF to addr 0 → rsp_err=1 and shadow unchanged (read returns 0x123).
   - COMMIT → rsp_err=1, no cfg_update.
   - STATUS read returns 0x002.
5. Read addr 30 → rsp_err=1, rsp_rdata=0. Hold rsp_ready=0 for 5 cycles → rsp_valid stays 1, req_ready stays 0, response unchanged.
6. Write addr 0 with 0x2AA, then assert rst in the RESP cycle → next cycle rsp_valid=0, cfg_out=RESET_VAL, locked=0, pending=0, no cfg_update.
